// File: rtl/uart_pkg.sv
// Constants shared by the UART receiver and the future transmitter:
// FSM state encoding, oversampling ratio and default frame shape.
package uart_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned MID_TICK   = 7;

    localparam int unsigned DEF_DATA_BITS  = 8;
    localparam int unsigned DEF_STOP_TICKS = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// Both flops reset to RESET_VAL so the output is clean from reset onwards.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver: qualifies the start bit at mid-bit, samples
// each data bit at mid-bit (LSB first), checks the stop bit and strobes the result.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
    parameter int unsigned STOP_TICKS = DEF_STOP_TICKS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    input  logic                 s_tick,
    output logic [DATA_BITS-1:0] dout,
    output logic                 rx_done_tick,
    output logic                 frame_err
);

    localparam int unsigned NW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [3:0]    S_MID  = 4'(MID_TICK);
    localparam logic [3:0]    S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]    S_STOP = 4'(STOP_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    logic                 rx_s;
    logic [1:0]           state_q, state_d;
    logic [3:0]           s_q, s_d;
    logic [NW-1:0]        n_q, n_d;
    logic [DATA_BITS-1:0] b_q, b_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 done_q, done_d;
    logic                 ferr_q, ferr_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID) begin
                        // A line that is high again at mid start bit was only a glitch
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = DATA_BITS'({rx_s, b_q} >> 1);
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP) begin
                        state_d = IDLE;
                        s_d     = '0;
                        if (rx_s) begin
                            dout_d = b_q;
                            done_d = 1'b1;
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
        end
    end

    assign dout         = dout_q;
    assign rx_done_tick = done_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a table of whole frames plus hand-written glitch
// and mid-frame reset sequences. Baud rate is scaled down (5 clk per tick).
module tb_uart_rx;

    localparam int TICK_DIV     = 5;
    localparam int BIT_CLK      = 16 * TICK_DIV;
    localparam int BAD_STOP_CLK = 56;   // low stop bit, released before a false start qualifies

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    int tdiv = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int both_cnt = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bit_clk;
        int         gap_clk;
        int         exp_done;
        int         exp_ferr;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t vecs [8];

    uart_rx #(
        .DATA_BITS (8),
        .STOP_TICKS(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .s_tick      (s_tick),
        .dout        (dout),
        .rx_done_tick(rx_done_tick),
        .frame_err   (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (tdiv == TICK_DIV - 1) begin
            tdiv   <= 0;
            s_tick <= 1'b1;
        end else begin
            tdiv   <= tdiv + 1;
            s_tick <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rx_done_tick) done_cnt <= done_cnt + 1;
        if (frame_err) ferr_cnt <= ferr_cnt + 1;
        if (rx_done_tick && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bit_clk);
        rx = 1'b0;
        wait_clk(bit_clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bit_clk);
        end
        if (stop) begin
            rx = 1'b1;
            wait_clk(bit_clk);
        end else begin
            rx = 1'b0;
            wait_clk(BAD_STOP_CLK);
            rx = 1'b1;
            wait_clk(bit_clk - BAD_STOP_CLK);
        end
    endtask

    initial begin
        int d0, f0;
        logic [7:0] c3;

        vecs[0] = '{8'hA5, 1'b1, BIT_CLK,     0,           1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, BIT_CLK,     0,           1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, BIT_CLK,     0,           1, 0, 8'hFF};
        vecs[3] = '{8'h11, 1'b1, BIT_CLK,     0,           1, 0, 8'h11};
        vecs[4] = '{8'h3C, 1'b0, BIT_CLK,     2 * BIT_CLK, 0, 1, 8'h11};
        vecs[5] = '{8'h5A, 1'b1, BIT_CLK,     0,           1, 0, 8'h5A};
        vecs[6] = '{8'h96, 1'b1, BIT_CLK - 2, 0,           1, 0, 8'h96};
        vecs[7] = '{8'h96, 1'b1, BIT_CLK + 2, BIT_CLK,     1, 0, 8'h96};

        wait_clk(3);
        check("reset_dout", int'(dout), 0);
        check("reset_done", int'(rx_done_tick), 0);
        check("reset_ferr", int'(frame_err), 0);
        reset = 1'b0;
        wait_clk(200);

        // Frames run back to back unless a row asks for an idle gap
        for (int v = 0; v < 8; v++) begin
            d0 = done_cnt;
            f0 = ferr_cnt;
            send_frame(vecs[v].data, vecs[v].stop, vecs[v].bit_clk);
            wait_clk(vecs[v].gap_clk);
            check($sformatf("vec%0d_done", v), done_cnt - d0, vecs[v].exp_done);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
            check($sformatf("vec%0d_dout", v), int'(dout), int'(vecs[v].exp_dout));
        end

        // Glitch: three ticks low, then idle
        wait_clk(BIT_CLK);
        d0 = done_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_clk(3 * TICK_DIV);
        rx = 1'b1;
        wait_clk(3 * BIT_CLK);
        check("glitch_done", done_cnt - d0, 0);
        check("glitch_ferr", ferr_cnt - f0, 0);
        check("glitch_dout", int'(dout), 8'h96);

        // Reset during data bit 4 of 0xC3; the sender keeps driving the rest
        c3 = 8'hC3;
        rx = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rx = c3[i];
            wait_clk(BIT_CLK);
        end
        rx = c3[4];
        wait_clk(BIT_CLK / 2);
        d0 = done_cnt;
        f0 = ferr_cnt;
        reset = 1'b1;
        #1;
        check("midrst_dout", int'(dout), 0);
        check("midrst_done", int'(rx_done_tick), 0);
        check("midrst_ferr", int'(frame_err), 0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(BIT_CLK / 2 - 3);
        for (int i = 5; i < 8; i++) begin
            rx = c3[i];
            wait_clk(BIT_CLK);
        end
        rx = 1'b1;
        wait_clk(BIT_CLK);
        check("midrst_no_strobe", done_cnt - d0, 0);
        check("midrst_no_ferr", ferr_cnt - f0, 0);
        check("midrst_dout_held", int'(dout), 0);

        // Idle long enough for any false start from the frame tail to drain
        wait_clk(12 * BIT_CLK);
        d0 = done_cnt;
        f0 = ferr_cnt;
        send_frame(8'h7E, 1'b1, BIT_CLK);
        wait_clk(BIT_CLK);
        check("after_rst_done", done_cnt - d0, 1);
        check("after_rst_ferr", ferr_cnt - f0, 0);
        check("after_rst_dout", int'(dout), 8'h7E);

        check("never_both_strobes", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
